// File: rtl/clint_pkg.sv
// Shared types and constants for the multi-source core-local interrupt controller.
package clint_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_STAT,
        S_R_STAT,
        S_ASSERT
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int CAUSE_ECALL    = 11;
    localparam int CAUSE_EBREAK   = 3;
    localparam int IRQ_CAUSE_BASE = 16;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    // A single request line still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clint_mc_if.sv
// Output bundle of clint_mc: CSR write port, pipeline stall and fetch redirect with acks.
interface clint_mc_if #(
    parameter int XLEN  = 32,
    parameter int N_SRC = 4
);
    logic              clint_wen_o;
    logic [11:0]       clint_waddr_o;
    logic [XLEN-1:0]   clint_wdata_o;
    logic              clint_busy_o;
    logic              int_assert_o;
    logic [XLEN-1:0]   int_addr_o;
    logic [N_SRC-1:0]  int_ack_o;

    modport master (
        output clint_wen_o, clint_waddr_o, clint_wdata_o, clint_busy_o,
               int_assert_o, int_addr_o, int_ack_o
    );

    modport slave (
        input  clint_wen_o, clint_waddr_o, clint_wdata_o, clint_busy_o,
               int_assert_o, int_addr_o, int_ack_o
    );
endinterface

// File: rtl/clint_prio_enc.sv
// Fixed-priority encoder over the masked interrupt lines; the lowest index wins.
module clint_prio_enc
    import clint_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Walking downwards lets the lowest set line overwrite any higher one.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/clint_mc.sv
// Multi-source CLINT: sequences mepc/mcause/mstatus writes for traps and mret, then redirects fetch.
// Optional vectored interrupt dispatch is compiled in with macro CLINT_VECTORED_EN.
module clint_mc
    import clint_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int N_SRC   = 4,
    parameter int CAUSE_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [XLEN-1:0]  jump_addr_i,
    input  logic [XLEN-1:0]  csr_mtvec_i,
    input  logic [XLEN-1:0]  csr_mepc_i,
    input  logic [XLEN-1:0]  csr_mstatus_i,
    input  logic [XLEN-1:0]  csr_mie_i,
    input  logic [N_SRC-1:0] int_req_i,
    clint_mc_if.master       bus
);

    localparam int IDX_W = idx_width(N_SRC);

    state_e             state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic               irq_q, irq_d;
    logic               mret_q, mret_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [N_SRC-1:0]   masked_req;
    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;
    logic [XLEN-1:0]    trap_addr;

    logic               wen, busy, asrt;
    logic [11:0]        waddr;
    logic [XLEN-1:0]    wdata, addr;
    logic [N_SRC-1:0]   ack;

    logic unused_bits;
    assign unused_bits = ^{csr_mie_i, csr_mtvec_i[1:0]};

    assign masked_req = int_req_i & csr_mie_i[IRQ_CAUSE_BASE +: N_SRC];

    clint_prio_enc #(.N(N_SRC), .IDX_W(IDX_W)) u_prio (
        .req_i   (masked_req),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

`ifdef CLINT_VECTORED_EN
    always_comb begin
        trap_addr = {csr_mtvec_i[XLEN-1:2], 2'b00};
        if (irq_q && csr_mtvec_i[1:0] == 2'b01)
            trap_addr = trap_addr + {{(XLEN-CAUSE_W-2){1'b0}}, cause_q, 2'b00};
    end
`else
    assign trap_addr = {csr_mtvec_i[XLEN-1:2], 2'b00};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            irq_q   <= 1'b0;
            mret_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            irq_q   <= irq_d;
            mret_q  <= mret_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        irq_d   = irq_q;
        mret_d  = mret_q;
        idx_d   = idx_q;
        wen     = 1'b0;
        waddr   = '0;
        wdata   = '0;
        busy    = 1'b0;
        asrt    = 1'b0;
        addr    = '0;
        ack     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (inst_i == INST_ECALL || inst_i == INST_EBREAK) begin
                    busy    = 1'b1;
                    cause_d = (inst_i == INST_ECALL) ? CAUSE_W'(CAUSE_ECALL) : CAUSE_W'(CAUSE_EBREAK);
                    epc_d   = inst_addr_i;
                    irq_d   = 1'b0;
                    mret_d  = 1'b0;
                    state_d = S_W_EPC;
                end else if (inst_i == INST_MRET) begin
                    busy    = 1'b1;
                    irq_d   = 1'b0;
                    mret_d  = 1'b1;
                    state_d = S_R_STAT;
                end else if (csr_mstatus_i[MIE_BIT] && irq_valid) begin
                    busy    = 1'b1;
                    cause_d = CAUSE_W'(IRQ_CAUSE_BASE + int'(irq_idx));
                    // An interrupt must resume at the redirect target, not the squashed instruction.
                    epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
                    irq_d   = 1'b1;
                    mret_d  = 1'b0;
                    idx_d   = irq_idx;
                    state_d = S_W_EPC;
                end
            end
            S_W_EPC: begin
                busy    = 1'b1;
                wen     = 1'b1;
                waddr   = CSR_MEPC;
                wdata   = epc_q;
                state_d = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                busy    = 1'b1;
                wen     = 1'b1;
                waddr   = CSR_MCAUSE;
                wdata   = {irq_q, {(XLEN-1-CAUSE_W){1'b0}}, cause_q};
                state_d = S_W_STAT;
            end
            S_W_STAT: begin
                busy            = 1'b1;
                wen             = 1'b1;
                waddr           = CSR_MSTATUS;
                wdata           = csr_mstatus_i;
                wdata[MPIE_BIT] = csr_mstatus_i[MIE_BIT];
                wdata[MIE_BIT]  = 1'b0;
                state_d         = S_ASSERT;
            end
            S_R_STAT: begin
                busy            = 1'b1;
                wen             = 1'b1;
                waddr           = CSR_MSTATUS;
                wdata           = csr_mstatus_i;
                wdata[MIE_BIT]  = csr_mstatus_i[MPIE_BIT];
                wdata[MPIE_BIT] = 1'b1;
                state_d         = S_ASSERT;
            end
            S_ASSERT: begin
                busy    = 1'b1;
                asrt    = 1'b1;
                addr    = mret_q ? csr_mepc_i : trap_addr;
                ack     = irq_q ? (N_SRC'(1) << idx_q) : '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.clint_wen_o   = wen;
    assign bus.clint_waddr_o = waddr;
    assign bus.clint_wdata_o = wdata;
    assign bus.clint_busy_o  = busy;
    assign bus.int_assert_o  = asrt;
    assign bus.int_addr_o    = addr;
    assign bus.int_ack_o     = ack;

endmodule
